// File: rtl/fir_out_decim.sv
// FIR output stage: decimate by DECIM, arithmetic-shift scale, saturate to OUT_WIDTH,
// buffer in a show-ahead FIFO. Define FIR_DECIM_ROUND_EN for round-half-up before the shift.
module fir_out_decim #(
    parameter int IN_WIDTH   = 18,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 8,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [IN_WIDTH-1:0]               input_data,
    input  logic                              input_data_flag,
    output logic [OUT_WIDTH-1:0]              output_data,
    output logic                              output_data_flag,
    input  logic                              output_ready,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
    output logic                              overflow,
    input  logic                              clear_overflow
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

    // ---------------- decimation ----------------
    logic [PW-1:0] phase;
    logic          keep;

    assign keep = input_data_flag && (phase == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (input_data_flag) begin
            phase <= (phase == PW'(DECIM-1)) ? '0 : phase + 1'b1;
        end
    end

    // ---------------- scale + saturate ----------------
    logic signed [IN_WIDTH:0]  ext;
    logic signed [IN_WIDTH:0]  biased;
    logic signed [IN_WIDTH:0]  shifted;
    logic        [OUT_WIDTH-1:0] sat;

    assign ext = {input_data[IN_WIDTH-1], input_data};

`ifdef FIR_DECIM_ROUND_EN
    // Half-LSB offset; the extra sign bit in ext absorbs the carry.
    localparam logic signed [IN_WIDTH:0] RND =
        (SHIFT > 0) ? ((IN_WIDTH+1)'(1) << ((SHIFT > 0) ? SHIFT-1 : 0)) : '0;
    assign biased = ext + RND;
`else
    assign biased = ext;
`endif

    assign shifted = biased >>> SHIFT;

    always_comb begin
        sat = shifted[OUT_WIDTH-1:0];
        if (shifted > SAT_MAX)      sat = SAT_MAX[OUT_WIDTH-1:0];
        else if (shifted < SAT_MIN) sat = SAT_MIN[OUT_WIDTH-1:0];
    end

    // ---------------- stage 1 register ----------------
    logic                 s1_vld;
    logic [OUT_WIDTH-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_vld <= keep;
            if (keep) s1_data <= sat;
        end
    end

    // ---------------- show-ahead FIFO ----------------
    logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic [OUT_WIDTH-1:0] last_pop;
    logic                 pop, full, accept, drop;

    assign full   = (count == CW'(FIFO_DEPTH));
    assign pop    = (count != '0) && output_ready;
    // A pop in the same cycle frees the slot the incoming write needs.
    assign accept = s1_vld && (!full || pop);
    assign drop   = s1_vld && full && !pop;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= s1_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_pop <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                last_pop <= mem[rd_ptr];
            end
            count <= count + CW'(accept) - CW'(pop);
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    assign fifo_count       = count;
    assign output_data_flag = (count != '0);
    assign output_data      = (count != '0) ? mem[rd_ptr] : last_pop;

endmodule

// File: doc/fir_out_decim.md
Name: fir_out_decim

Overview:
Downstream stage of the FIR filter. Consumes the filter's output sample stream and decimates it by DECIM. Scales each kept sample by an arithmetic right shift and saturates it to OUT_WIDTH. Buffers results in a small show-ahead FIFO, presented to the next consumer through a valid/ready handshake.

Parameters:
IN_WIDTH, 18, width of the signed FIR result (8-bit data + 8-bit coef + 2 growth bits for 3 taps)
OUT_WIDTH, 8, width of the signed output sample
SHIFT, 8, arithmetic right-shift amount applied before saturation (0..IN_WIDTH-1)
DECIM, 2, decimation factor (>=1); 1 keeps every sample
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
input_data  input  IN_WIDTH  signed FIR result
input_data_flag  input  1  one-cycle strobe: input_data valid this cycle
output_data  output  OUT_WIDTH  signed FIFO head sample
output_data_flag  output  1  FIFO non-empty (head valid)
output_ready  input  1  consumer accepts head this cycle
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently stored
overflow  output  1  sticky: a kept sample was dropped because FIFO full
clear_overflow  input  1  clears overflow

Behaviour:
- Reset: output_data=0, output_data_flag=0, fifo_count=0, overflow=0, decimation phase=0, pipeline stage invalid, FIFO pointers=0. Reset mid-operation discards all stored and in-flight samples. The first strobe after reset is kept.
- Decimation: phase counter 0..DECIM-1 advances only on input_data_flag and wraps DECIM-1 -> 0. A sample is kept when the strobe arrives with phase==0. Samples without a strobe are ignored.
- Scaling: sign-extend to IN_WIDTH+1, then arithmetic shift right by SHIFT (floor).
- Saturation: result > 2^(OUT_WIDTH-1)-1 -> max positive; result < -2^(OUT_WIDTH-1) -> min negative; otherwise the low OUT_WIDTH bits.
- Pipeline: scaled/saturated value is registered in stage 1 on the strobe edge, then written to the FIFO on the following edge.
- Latency: strobe in cycle N -> FIFO write at end of N+1 -> output_data_flag=1 and output_data valid in cycle N+2, if the FIFO was empty.
- FIFO: show-ahead. output_data_flag = (fifo_count != 0). Pop occurs when output_data_flag && output_ready. output_ready while empty has no effect. output_data holds the last popped value when empty (0 after reset).
- Full: a write arriving when count==FIFO_DEPTH and no pop that cycle is dropped; overflow set; count unchanged.
- Simultaneous push+pop: full case -> the pop frees a slot and the push is accepted, count unchanged, no overflow. Non-full case -> count unchanged.
- Order: strictly FIFO, read and write pointers wrap modulo FIFO_DEPTH.
- overflow: clear_overflow=1 clears it next edge. If a drop occurs in the same cycle, set wins.
- No combinational path from input_data_flag to any output. output_ready affects only next-cycle state.

Optional Feature:
FIR_DECIM_ROUND_EN
- Defined: add 2^(SHIFT-1) to the sign-extended value before the shift (round half toward +inf). The extra width bit prevents wrap, and saturation follows. With SHIFT=0 no offset is added.
- Undefined: pure truncation (floor), no adder.
- Latency identical in both builds.

Test Plan:
1. Reset: assert rst 2 cycles with junk strobes -> output_data=0x00, output_data_flag=0, fifo_count=0, overflow=0 throughout and after release.
2. Decimation/latency (DECIM=2, SHIFT=8, output_ready=1): strobes with 0x00A80, 0x00500, 0x00300 at cycles 0, 10, 20 -> 0x0A valid in cycle 2 and 0x03 valid in cycle 22; 0x00500 is never output; each flag lasts 1 cycle.
3. Saturation: kept inputs 0x1FFFF and 0x20000 -> outputs 0x7F then 0x80.
4. Rounding: kept inputs 0x00180 and 0x3FE80 -> without macro 0x01, 0xFE; with FIR_DECIM_ROUND_EN 0x02, 0xFF.
5. Overflow: output_ready=0, five kept samples 1..5 (scaled) -> fifo_count=4, overflow=1. Set output_ready=1 -> pops 1,2,3,4 on consecutive cycles, then flag=0. Pulse clear_overflow -> overflow=0. Repeat with a pop in the same cycle as the full-FIFO push -> no overflow.
6. Reset mid-operation: fifo_count=3, phase=1, assert rst one cycle -> count 0, flag 0. The next strobe is kept and appears 2 cycles later.
